// File: rtl/tile_fetch_pkg.sv
// Shared constants, field codes and FSM encoding for the tile fetch path.
package tile_fetch_pkg;

  localparam int TILE_WIDTH   = 4;
  localparam int TILE_HEIGHT  = 4;
  localparam int TILE_X_SHIFT = $clog2(TILE_WIDTH);
  localparam int TILE_Y_SHIFT = $clog2(TILE_HEIGHT);

  // Bit offsets of the fields inside one 8-bit tile-map entry
  localparam int MAP_TILE_LSB   = 0;
  localparam int MAP_MIRROR_LSB = 4;
  localparam int MAP_ROTATE_LSB = 6;

  typedef enum logic [1:0] {
    mirrorNO = 2'd0,
    mirrorH  = 2'd1,
    mirrorV  = 2'd2,
    mirrorVH = 2'd3
  } mirror_t;

  typedef enum logic [1:0] {
    rotateNO  = 2'd0,
    rotate90  = 2'd1,
    rotate180 = 2'd2,
    rotate270 = 2'd3
  } rotate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAP  = 2'd1,
    TILE = 2'd2,
    OUT  = 2'd3
  } state_t;

  function automatic logic [3:0] entry_tile_no(input logic [7:0] entry);
    return entry[MAP_TILE_LSB +: 4];
  endfunction

  function automatic mirror_t entry_mirror(input logic [7:0] entry);
    return mirror_t'(entry[MAP_MIRROR_LSB +: 2]);
  endfunction

  function automatic rotate_t entry_rotate(input logic [7:0] entry);
    return rotate_t'(entry[MAP_ROTATE_LSB +: 2]);
  endfunction

endpackage

// File: rtl/tile_fetch_coord.sv
// Splits a screen pixel into tile-map cell (col,row), texel position inside
// the tile and an in-area flag. Purely combinational so sprite logic can reuse it.
module tile_coord
  import tile_fetch_pkg::*;
#(
  parameter int MAP_COLS   = 20,
  parameter int MAP_ROWS   = 15,
  parameter int SCALE_LOG2 = 3
) (
  input  logic [9:0] px_x,
  input  logic [9:0] px_y,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic [1:0] tile_x,
  output logic [1:0] tile_y,
  output logic       in_area
);

  logic [9:0] texel_x;
  logic [9:0] texel_y;

  // Pixel -> texel -> (cell, texel-within-tile) and map bounds test
  always_comb begin
    texel_x = px_x >> SCALE_LOG2;
    texel_y = px_y >> SCALE_LOG2;
    col     = texel_x >> TILE_X_SHIFT;
    row     = texel_y >> TILE_Y_SHIFT;
    tile_x  = texel_x[TILE_X_SHIFT-1:0];
    tile_y  = texel_y[TILE_Y_SHIFT-1:0];
    in_area = (col < 10'(MAP_COLS)) && (row < 10'(MAP_ROWS));
  end

endmodule

// File: rtl/tile_fetch.sv
// Pixel-to-texel fetch: looks up the tile map (with a one-entry cache),
// requests the texel colour and returns it through a one-cycle strobe.
// Both memory handshakes are bounded by a wait counter.
module tile_fetch
  import tile_fetch_pkg::*;
#(
  parameter int          MAP_COLS   = 20,
  parameter int          MAP_ROWS   = 15,
  parameter int          MAP_AW     = 9,
  parameter int          SCALE_LOG2 = 3,
  parameter logic [23:0] BG_COLOR   = 24'h000000,
  parameter logic [23:0] ERR_COLOR  = 24'hFF00FF,
  parameter int          TIMEOUT    = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_px_valid,
  input  logic [9:0]        i_px_x,
  input  logic [9:0]        i_px_y,
  output logic              o_px_ready,
  input  logic              i_map_dirty,
  output logic [MAP_AW-1:0] o_map_address,
  output logic              o_map_read,
  input  logic [7:0]        i_map_data,
  input  logic              i_map_valid,
  output logic [3:0]        o_tile_no,
  output logic [1:0]        o_tile_x,
  output logic [1:0]        o_tile_y,
  output logic [1:0]        o_mirror,
  output logic [1:0]        o_rotate,
  output logic              o_read,
  input  logic [23:0]       i_rgb_data,
  input  logic              i_valid,
  output logic [23:0]       o_rgb,
  output logic              o_rgb_valid,
  output logic              o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t state;
  state_t state_next;

  logic [9:0]        coord_col;
  logic [9:0]        coord_row;
  logic [1:0]        coord_tile_x;
  logic [1:0]        coord_tile_y;
  logic              coord_in_area;
  logic [MAP_AW-1:0] coord_address;

  logic [9:0]        req_col;
  logic [9:0]        req_row;
  logic [MAP_AW-1:0] map_address;
  logic [3:0]        tile_no;
  logic [1:0]        tile_x;
  logic [1:0]        tile_y;
  mirror_t           mirror;
  rotate_t           rotate;
  logic [23:0]       rgb;
  logic              timed_out;

  logic              cache_valid;
  logic [9:0]        cache_col;
  logic [9:0]        cache_row;
  logic [7:0]        cache_entry;
  logic              cache_hit;
  logic              dirty_seen;

  logic [CNT_W-1:0]  wait_cnt;
  logic              wait_expired;

  tile_coord #(
    .MAP_COLS  (MAP_COLS),
    .MAP_ROWS  (MAP_ROWS),
    .SCALE_LOG2(SCALE_LOG2)
  ) u_coord (
    .px_x   (i_px_x),
    .px_y   (i_px_y),
    .col    (coord_col),
    .row    (coord_row),
    .tile_x (coord_tile_x),
    .tile_y (coord_tile_y),
    .in_area(coord_in_area)
  );

  // Only meaningful for in-area cells, where the product always fits MAP_AW
  assign coord_address = MAP_AW'(coord_row) * MAP_AW'(MAP_COLS) + MAP_AW'(coord_col);

  // A dirty pulse on the accept edge must not be allowed to hit a stale entry
  assign cache_hit = cache_valid && !i_map_dirty &&
                     (cache_col == coord_col) && (cache_row == coord_row);

  // The final waiting cycle: the counter would reach TIMEOUT on this edge
  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));

  assign o_map_address = map_address;
  assign o_tile_no     = tile_no;
  assign o_tile_x      = tile_x;
  assign o_tile_y      = tile_y;
  assign o_mirror      = mirror;
  assign o_rotate      = rotate;
  assign o_rgb         = rgb;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs; memory valid wins over an expiring wait
  always_comb begin
    state_next  = state;
    o_px_ready  = 1'b0;
    o_map_read  = 1'b0;
    o_read      = 1'b0;
    o_rgb_valid = 1'b0;
    o_timeout   = 1'b0;
    case (state)
      IDLE: begin
        o_px_ready = 1'b1;
        if (i_px_valid) begin
          if (!coord_in_area) state_next = OUT;
          else if (cache_hit) state_next = TILE;
          else                state_next = MAP;
        end
      end
      MAP: begin
        o_map_read = 1'b1;
        if (i_map_valid)       state_next = TILE;
        else if (wait_expired) state_next = OUT;
      end
      TILE: begin
        o_read = 1'b1;
        if (i_valid || wait_expired) state_next = OUT;
      end
      OUT: begin
        o_rgb_valid = 1'b1;
        o_timeout   = timed_out;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request registers, map cache, wait counter and result colour
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_col     <= '0;
      req_row     <= '0;
      map_address <= '0;
      tile_no     <= '0;
      tile_x      <= '0;
      tile_y      <= '0;
      mirror      <= mirrorNO;
      rotate      <= rotateNO;
      rgb         <= '0;
      timed_out   <= 1'b0;
      cache_valid <= 1'b0;
      cache_col   <= '0;
      cache_row   <= '0;
      cache_entry <= '0;
      dirty_seen  <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      if (i_map_dirty) cache_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_px_valid) begin
            req_col    <= coord_col;
            req_row    <= coord_row;
            tile_x     <= coord_tile_x;
            tile_y     <= coord_tile_y;
            timed_out  <= 1'b0;
            dirty_seen <= 1'b0;
            wait_cnt   <= '0;
            if (!coord_in_area) begin
              rgb <= BG_COLOR;
            end else if (cache_hit) begin
              tile_no <= entry_tile_no(cache_entry);
              mirror  <= entry_mirror(cache_entry);
              rotate  <= entry_rotate(cache_entry);
            end else begin
              map_address <= coord_address;
            end
          end
        end
        MAP: begin
          dirty_seen <= dirty_seen | i_map_dirty;
          if (i_map_valid) begin
            tile_no     <= entry_tile_no(i_map_data);
            mirror      <= entry_mirror(i_map_data);
            rotate      <= entry_rotate(i_map_data);
            cache_entry <= i_map_data;
            cache_col   <= req_col;
            cache_row   <= req_row;
            cache_valid <= !(dirty_seen || i_map_dirty);
            wait_cnt    <= '0;
          end else if (wait_expired) begin
            rgb         <= ERR_COLOR;
            timed_out   <= 1'b1;
            cache_valid <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        TILE: begin
          if (i_valid) begin
            rgb <= i_rgb_data;
          end else if (wait_expired) begin
            rgb       <= ERR_COLOR;
            timed_out <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_fetch.sv
// Scoreboard bench for tile_fetch: requests push an expected result built from
// a small reference model; a monitor pops and compares on every o_rgb_valid.
module tb_tile_fetch;

  localparam int          MAP_COLS   = 20;
  localparam int          MAP_ROWS   = 15;
  localparam int          MAP_AW     = 9;
  localparam int          SCALE_LOG2 = 3;
  localparam int          TIMEOUT    = 15;
  localparam logic [23:0] BG_COLOR   = 24'h000000;
  localparam logic [23:0] ERR_COLOR  = 24'hFF00FF;

  typedef struct {
    logic [23:0]       rgb;
    logic              timeout;
    int                latency;
    logic              map_rd;
    logic              tex_rd;
    logic [MAP_AW-1:0] address;
    logic [11:0]       fields;
  } expect_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              i_px_valid;
  logic [9:0]        i_px_x;
  logic [9:0]        i_px_y;
  logic              o_px_ready;
  logic              i_map_dirty;
  logic [MAP_AW-1:0] o_map_address;
  logic              o_map_read;
  logic [7:0]        i_map_data;
  logic              i_map_valid;
  logic [3:0]        o_tile_no;
  logic [1:0]        o_tile_x;
  logic [1:0]        o_tile_y;
  logic [1:0]        o_mirror;
  logic [1:0]        o_rotate;
  logic              o_read;
  logic [23:0]       i_rgb_data;
  logic              i_valid;
  logic [23:0]       o_rgb;
  logic              o_rgb_valid;
  logic              o_timeout;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cycle_count  = 0;
  int          accept_cycle = 0;
  int          results_seen = 0;
  int          map_rd_cycles = 0;
  int          tex_rd_cycles = 0;
  int          map_delay = 0;
  int          tex_delay = 0;
  int          map_cnt = 0;
  int          tex_cnt = 0;
  logic [23:0] rgb_resp = 24'h0;
  logic        dirty_arm = 1'b0;
  logic        dirty_pulse = 1'b0;
  logic        dirty_in_map = 1'b0;
  logic [7:0]  map_mem [0:511];
  expect_t     sb_queue [$];

  logic        m_cache_valid = 1'b0;
  int          m_cache_col = 0;
  int          m_cache_row = 0;

  assign i_map_dirty = dirty_pulse | dirty_in_map;

  tile_fetch #(
    .MAP_COLS  (MAP_COLS),
    .MAP_ROWS  (MAP_ROWS),
    .MAP_AW    (MAP_AW),
    .SCALE_LOG2(SCALE_LOG2),
    .BG_COLOR  (BG_COLOR),
    .ERR_COLOR (ERR_COLOR),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .i_clk        (clock),
    .i_rst        (reset),
    .i_px_valid   (i_px_valid),
    .i_px_x       (i_px_x),
    .i_px_y       (i_px_y),
    .o_px_ready   (o_px_ready),
    .i_map_dirty  (i_map_dirty),
    .o_map_address(o_map_address),
    .o_map_read   (o_map_read),
    .i_map_data   (i_map_data),
    .i_map_valid  (i_map_valid),
    .o_tile_no    (o_tile_no),
    .o_tile_x     (o_tile_x),
    .o_tile_y     (o_tile_y),
    .o_mirror     (o_mirror),
    .o_rotate     (o_rotate),
    .o_read       (o_read),
    .i_rgb_data   (i_rgb_data),
    .i_valid      (i_valid),
    .o_rgb        (o_rgb),
    .o_rgb_valid  (o_rgb_valid),
    .o_timeout    (o_timeout)
  );

  always #5 clock = ~clock;

  // Free-running cycle counter used to measure accept-to-result latency
  always @(posedge clock) cycle_count = cycle_count + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run = tests_run + 1;
    if (actual !== expected) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Memory models: answer after a programmable number of wait cycles
  always @(negedge clock) begin
    if (o_map_read) begin
      i_map_valid  = (map_cnt >= map_delay);
      i_map_data   = i_map_valid ? map_mem[o_map_address] : 8'hEE;
      dirty_in_map = dirty_arm && (map_cnt == 0);
      map_cnt      = map_cnt + 1;
    end else begin
      i_map_valid  = 1'b0;
      i_map_data   = 8'hEE;
      dirty_in_map = 1'b0;
      map_cnt      = 0;
    end
    if (o_read) begin
      i_valid    = (tex_cnt >= tex_delay);
      i_rgb_data = i_valid ? rgb_resp : 24'hEEEEEE;
      tex_cnt    = tex_cnt + 1;
    end else begin
      i_valid    = 1'b0;
      i_rgb_data = 24'hEEEEEE;
      tex_cnt    = 0;
    end
  end

  // Monitor: request fields while reading, scoreboard pop on every result
  always @(negedge clock) begin
    expect_t e;
    if (o_map_read) begin
      map_rd_cycles = map_rd_cycles + 1;
      if (sb_queue.size() > 0) checkOutput("map_address", 32'(o_map_address), 32'(sb_queue[0].address));
    end
    if (o_read) begin
      tex_rd_cycles = tex_rd_cycles + 1;
      if (sb_queue.size() > 0)
        checkOutput("tile_fields", 32'({o_tile_no, o_tile_x, o_tile_y, o_mirror, o_rotate}),
                    32'(sb_queue[0].fields));
    end
    if (o_rgb_valid) begin
      if (sb_queue.size() == 0) begin
        checkOutput("spurious_valid", 32'(o_rgb_valid), 32'd0);
      end else begin
        e = sb_queue.pop_front();
        checkOutput("rgb", 32'(o_rgb), 32'(e.rgb));
        checkOutput("timeout_flag", 32'(o_timeout), 32'(e.timeout));
        checkOutput("latency", 32'(cycle_count - accept_cycle + 1), 32'(e.latency));
        checkOutput("map_read_seen", 32'(map_rd_cycles != 0), 32'(e.map_rd));
        checkOutput("tex_read_seen", 32'(tex_rd_cycles != 0), 32'(e.tex_rd));
      end
      results_seen = results_seen + 1;
    end else if (o_timeout) begin
      checkOutput("stray_timeout", 32'(o_timeout), 32'd0);
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"},   32'(o_px_ready), 32'd1);
    checkOutput({tag, "_reads"},   32'({o_map_read, o_read}), 32'd0);
    checkOutput({tag, "_address"}, 32'(o_map_address), 32'd0);
    checkOutput({tag, "_fields"},  32'({o_tile_no, o_tile_x, o_tile_y, o_mirror, o_rotate}), 32'd0);
    checkOutput({tag, "_rgb"},     32'(o_rgb), 32'd0);
    checkOutput({tag, "_strobes"}, 32'({o_rgb_valid, o_timeout}), 32'd0);
  endtask

  // Handshake one pixel request; called at a negedge, returns one negedge after accept
  task automatic driveRequest(input int x, input int y);
    int guard = 0;
    while (!o_px_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!o_px_ready) checkOutput("ready_wait", 32'(o_px_ready), 32'd1);
    map_rd_cycles = 0;
    tex_rd_cycles = 0;
    i_px_valid    = 1'b1;
    i_px_x        = 10'(x);
    i_px_y        = 10'(y);
    accept_cycle  = cycle_count + 1;
    @(negedge clock);
    i_px_valid    = 1'b0;
  endtask

  task automatic waitResult(input int start);
    int guard = 0;
    while (results_seen == start && guard < 400) begin
      @(negedge clock);
      guard++;
    end
    if (results_seen == start) begin
      checkOutput("result_wait", 32'(results_seen - start), 32'd1);
      if (sb_queue.size() > 0) void'(sb_queue.pop_front());
    end
    @(negedge clock);
  endtask

  // Reference model for one request, scoreboard push, drive and wait
  task automatic applyStimulus(input int x, input int y);
    expect_t    e;
    int         texel_x, texel_y, col, row, addr, start;
    logic       hit, in_area, map_to;
    logic [7:0] entry;
    texel_x = x >> SCALE_LOG2;
    texel_y = y >> SCALE_LOG2;
    col     = texel_x >> 2;
    row     = texel_y >> 2;
    in_area = (col < MAP_COLS) && (row < MAP_ROWS);
    addr    = in_area ? row * MAP_COLS + col : 0;
    entry   = map_mem[addr];
    e.address = MAP_AW'(addr);
    e.fields  = {entry[3:0], 2'(texel_x % 4), 2'(texel_y % 4), entry[5:4], entry[7:6]};
    e.timeout = 1'b0;
    e.map_rd  = 1'b0;
    e.tex_rd  = 1'b0;
    e.latency = 1;
    e.rgb     = BG_COLOR;
    if (in_area) begin
      hit      = m_cache_valid && (m_cache_col == col) && (m_cache_row == row);
      map_to   = 1'b0;
      e.map_rd = !hit;
      if (!hit) begin
        if (map_delay <= TIMEOUT - 1) e.latency += map_delay + 1;
        else begin
          e.latency += TIMEOUT;
          map_to = 1'b1;
        end
        m_cache_valid = !map_to && !dirty_arm;
        m_cache_col   = col;
        m_cache_row   = row;
      end
      if (map_to) begin
        e.timeout = 1'b1;
      end else begin
        e.tex_rd = 1'b1;
        if (tex_delay <= TIMEOUT - 1) e.latency += tex_delay + 1;
        else begin
          e.latency += TIMEOUT;
          e.timeout = 1'b1;
        end
      end
      e.rgb = e.timeout ? ERR_COLOR : rgb_resp;
    end
    sb_queue.push_back(e);
    start = results_seen;
    driveRequest(x, y);
    waitResult(start);
  endtask

  task automatic pulseDirty();
    dirty_pulse = 1'b1;
    @(negedge clock);
    dirty_pulse = 1'b0;
    m_cache_valid = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    i_px_valid = 1'b0;
    i_px_x     = '0;
    i_px_y     = '0;
    for (int i = 0; i < 512; i++) map_mem[i] = 8'($urandom);
    map_mem[0] = 8'h00;
    map_mem[1] = 8'b01_10_0101;
    map_mem[3] = 8'hC3;
    repeat (3) @(negedge clock);
    checkResetState("reset");
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] zero-wait miss at (0,0)");
    rgb_resp = 24'h123456;
    applyStimulus(0, 0);

    $display("[TB] miss with delayed texel, then cache hit in the same cell");
    rgb_resp  = 24'hABCDEF;
    tex_delay = 4;
    applyStimulus(40, 8);
    tex_delay = 0;
    rgb_resp  = 24'h0F1E2D;
    applyStimulus(48, 8);

    $display("[TB] out-of-area and map edges");
    applyStimulus(700, 10);
    applyStimulus(640, 0);
    applyStimulus(0, 480);
    rgb_resp = 24'h55AA33;
    applyStimulus(639, 479);

    $display("[TB] texel timeout");
    rgb_resp  = 24'h777777;
    applyStimulus(40, 8);
    tex_delay = 1000;
    applyStimulus(48, 8);
    checkOutput("idle_after_timeout", 32'(o_px_ready), 32'd1);
    tex_delay = 0;

    $display("[TB] map timeout leaves cache invalid");
    map_delay = 1000;
    applyStimulus(0, 0);
    map_delay = 0;
    rgb_resp  = 24'h246801;
    applyStimulus(0, 0);
    applyStimulus(0, 0);

    $display("[TB] dirty between requests and during map fetch");
    pulseDirty();
    applyStimulus(0, 0);
    dirty_arm = 1'b1;
    map_delay = 2;
    rgb_resp  = 24'h13579B;
    applyStimulus(96, 0);
    dirty_arm = 1'b0;
    map_delay = 0;
    applyStimulus(96, 0);
    applyStimulus(100, 4);

    $display("[TB] random requests");
    for (int i = 0; i < 12; i++) begin
      int rx;
      int ry;
      rx        = (i % 6 == 5) ? 640 + $urandom_range(0, 100) : $urandom_range(0, 100);
      ry        = $urandom_range(0, 40);
      map_delay = $urandom_range(0, 3);
      tex_delay = $urandom_range(0, 3);
      rgb_resp  = 24'($urandom);
      applyStimulus(rx, ry);
    end
    map_delay = 0;
    tex_delay = 0;

    $display("[TB] reset during a map wait");
    map_delay = 1000;
    driveRequest(200, 200);
    repeat (3) @(negedge clock);
    checkOutput("map_wait_active", 32'(o_map_read), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    checkResetState("midreset");
    reset = 1'b0;
    m_cache_valid = 1'b0;
    map_delay = 0;
    repeat (20) @(negedge clock);
    rgb_resp = 24'hC0FFEE;
    applyStimulus(200, 200);

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
